// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the cons-cell memory unit among NUM_REQ requesters.
// Drives the unit's command port, tracks its is_ready handshake and returns results.
module mem_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [2*NUM_REQ-1:0]      req_func,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr0,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr1,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [ADDR_W-1:0]         rsp_addr,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      timeout_err,
    output logic                      busy,
    output logic [1:0]                mu_func,
    output logic                      mu_execute,
    output logic [ADDR_W-1:0]         mu_addr0,
    output logic [ADDR_W-1:0]         mu_addr1,
    input  logic                      mu_is_ready,
    input  logic [ADDR_W-1:0]         mu_addr_out,
    input  logic [DATA_W-1:0]         mu_data_out
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_ACK   = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [ADDR_W-1:0]  rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               timeout_err_q, timeout_err_d;
    logic               busy_q, busy_d;
    logic [1:0]         mu_func_q, mu_func_d;
    logic               mu_execute_q, mu_execute_d;
    logic [ADDR_W-1:0]  mu_addr0_q, mu_addr0_d;
    logic [ADDR_W-1:0]  mu_addr1_q, mu_addr1_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [WD_W-1:0]    wd_q, wd_d;

    logic [PTR_W-1:0]   win_idx;
    logic               win_found;
    logic [PTR_W-1:0]   cand_idx;
    int unsigned        cand;
    logic [NUM_REQ-1:0] win_oh;
    logic [1:0]         sel_func;
    logic [ADDR_W-1:0]  sel_addr0;
    logic [ADDR_W-1:0]  sel_addr1;
    logic               end_txn;
    logic               end_timeout;

    // First pending request scanning upward from rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Winner's operands and one-hot grant.
    always_comb begin
        win_oh    = '0;
        sel_func  = '0;
        sel_addr0 = '0;
        sel_addr1 = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_oh[i] = 1'b1;
                sel_func  = req_func[2*i +: 2];
                sel_addr0 = req_addr0[ADDR_W*i +: ADDR_W];
                sel_addr1 = req_addr1[ADDR_W*i +: ADDR_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        done_d        = '0;
        rsp_addr_d    = rsp_addr_q;
        rsp_data_d    = rsp_data_q;
        timeout_err_d = 1'b0;
        mu_func_d     = mu_func_q;
        mu_execute_d  = 1'b0;
        mu_addr0_d    = mu_addr0_q;
        mu_addr1_d    = mu_addr1_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        wd_d          = wd_q;
        end_txn       = 1'b0;
        end_timeout   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_found && mu_is_ready) begin
                    grant_d      = win_oh;
                    owner_d      = win_idx;
                    mu_func_d    = sel_func;
                    mu_addr0_d   = sel_addr0;
                    mu_addr1_d   = sel_addr1;
                    mu_execute_d = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_ACK;
            end
            S_ACK: begin
                if (wd_q == WD_LAST) begin
                    end_txn     = 1'b1;
                    end_timeout = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if (!mu_is_ready) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (mu_is_ready) begin
                    end_txn = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    end_txn     = 1'b1;
                    end_timeout = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Completion or watchdog abort: both release the owner and rotate priority.
        if (end_txn) begin
            done_d        = grant_q;
            grant_d       = '0;
            timeout_err_d = end_timeout;
            rr_ptr_d      = (owner_q == PTR_LAST) ? '0 : owner_q + PTR_W'(1);
            state_d       = S_IDLE;
            if (!end_timeout) begin
                rsp_addr_d = mu_addr_out;
                rsp_data_d = mu_data_out;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            done_q        <= '0;
            rsp_addr_q    <= '0;
            rsp_data_q    <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            mu_func_q     <= '0;
            mu_execute_q  <= 1'b0;
            mu_addr0_q    <= '0;
            mu_addr1_q    <= '0;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            rsp_addr_q    <= rsp_addr_d;
            rsp_data_q    <= rsp_data_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            mu_func_q     <= mu_func_d;
            mu_execute_q  <= mu_execute_d;
            mu_addr0_q    <= mu_addr0_d;
            mu_addr1_q    <= mu_addr1_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            wd_q          <= wd_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign rsp_addr    = rsp_addr_q;
    assign rsp_data    = rsp_data_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;
    assign mu_func     = mu_func_q;
    assign mu_execute  = mu_execute_q;
    assign mu_addr0    = mu_addr0_q;
    assign mu_addr1    = mu_addr1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural cons-cell memory unit.
module tb_mem_arbiter;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 24;
    localparam int unsigned TIMEOUT = 64;

    typedef struct {
        logic [NUM_REQ-1:0] oh;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  data;
        logic               to;
    } exp_t;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [2*NUM_REQ-1:0]      req_func;
    logic [ADDR_W*NUM_REQ-1:0] req_addr0;
    logic [ADDR_W*NUM_REQ-1:0] req_addr1;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic [ADDR_W-1:0]         rsp_addr;
    logic [DATA_W-1:0]         rsp_data;
    logic                      timeout_err;
    logic                      busy;
    logic [1:0]                mu_func;
    logic                      mu_execute;
    logic [ADDR_W-1:0]         mu_addr0;
    logic [ADDR_W-1:0]         mu_addr1;
    logic                      mu_is_ready;
    logic [ADDR_W-1:0]         mu_addr_out;
    logic [DATA_W-1:0]         mu_data_out;

    exp_t              sb[$];
    int                n_checks;
    int                n_pass;
    logic [ADDR_W-1:0] mdl_addr;
    logic [DATA_W-1:0] mdl_data;

    logic              mem_hold_low;
    int                mem_phase;
    logic [1:0]        mem_f;
    logic [ADDR_W-1:0] mem_a0;

    mem_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_func(req_func),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .grant(grant), .done(done), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .timeout_err(timeout_err), .busy(busy),
        .mu_func(mu_func), .mu_execute(mu_execute),
        .mu_addr0(mu_addr0), .mu_addr1(mu_addr1),
        .mu_is_ready(mu_is_ready), .mu_addr_out(mu_addr_out), .mu_data_out(mu_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] cell_val(input logic [ADDR_W-1:0] a);
        if (a == 10'h005) return 24'h00C807;
        return {4'h3, a ^ 10'h155, a};
    endfunction

    function automatic logic [ADDR_W-1:0] mem_addr_of(input logic [1:0] f, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = cell_val(a);
        case (f)
            2'b00:   return v[19:10];
            2'b01:   return v[9:0];
            default: return a;
        endcase
    endfunction

    // Memory unit: drops is_ready one cycle after sampling execute, re-readies two cycles
    // later with results; cons never completes until the unit is reset via mem_hold_low.
    always @(posedge clk) begin
        if (mem_hold_low) begin
            mu_is_ready <= 1'b0;
            mem_phase   <= 0;
            mu_addr_out <= '0;
            mu_data_out <= '0;
        end else begin
            case (mem_phase)
                0: begin
                    mu_is_ready <= 1'b1;
                    if (mu_execute) begin
                        mem_f     <= mu_func;
                        mem_a0    <= mu_addr0;
                        mem_phase <= 1;
                    end
                end
                1: begin
                    mu_is_ready <= 1'b0;
                    mem_phase   <= 2;
                end
                2: mem_phase <= (mem_f == 2'b10) ? 4 : 3;
                3: begin
                    mu_is_ready <= 1'b1;
                    mu_addr_out <= mem_addr_of(mem_f, mem_a0);
                    mu_data_out <= cell_val(mem_a0);
                    mem_phase   <= 0;
                end
                default: ;
            endcase
        end
    end

    // Scoreboard: every done pulse pops and checks the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done !== '0) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_done: done=%b with no transaction expected", done);
            end else begin
                e = sb.pop_front();
                if (done !== e.oh || rsp_addr !== e.addr || rsp_data !== e.data || timeout_err !== e.to)
                    $display("FAIL sb_done: got done=%b addr=%h data=%h to=%b, expected done=%b addr=%h data=%h to=%b",
                             done, rsp_addr, rsp_data, timeout_err, e.oh, e.addr, e.data, e.to);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_req(input int i, input logic [1:0] f,
                             input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        req[i] = 1'b1;
        req_func[2*i +: 2] = f;
        req_addr0[ADDR_W*i +: ADDR_W] = a0;
        req_addr1[ADDR_W*i +: ADDR_W] = a1;
    endtask

    task automatic push_exp(input int i, input logic [1:0] f, input logic [ADDR_W-1:0] a0);
        exp_t e;
        e.oh    = '0;
        e.oh[i] = 1'b1;
        if (f == 2'b10) begin
            e.to   = 1'b1;
            e.addr = mdl_addr;
            e.data = mdl_data;
        end else begin
            e.to     = 1'b0;
            e.addr   = mem_addr_of(f, a0);
            e.data   = cell_val(a0);
            mdl_addr = e.addr;
            mdl_data = e.data;
        end
        sb.push_back(e);
    endtask

    task automatic wait_grant(output logic [NUM_REQ-1:0] g, output bit ok);
        ok = 1'b0;
        g  = '0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (grant !== '0) begin
                ok = 1'b1;
                g  = grant;
                break;
            end
        end
    endtask

    task automatic wait_done(output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            lat++;
            if (done !== '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst          = 1'b1;
        req          = '0;
        mem_hold_low = 1'b1;
        tick();
        tick();
        mem_hold_low = 1'b0;
        rst          = 1'b0;
        mdl_addr     = '0;
        mdl_data     = '0;
        sb.delete();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        mem_hold_low = 1'b1;
        req          = '0;
        req_func     = '0;
        req_addr0    = '0;
        req_addr1    = '0;
        mdl_addr     = '0;
        mdl_data     = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({grant, done, timeout_err, busy, mu_execute} !== '0)
            $display("FAIL reset_ctrl: grant=%b done=%b to=%b busy=%b exec=%b, expected all 0",
                     grant, done, timeout_err, busy, mu_execute);
        else n_pass++;
        n_checks++;
        if ({rsp_addr, rsp_data, mu_func, mu_addr0, mu_addr1} !== '0)
            $display("FAIL reset_data: rsp=%h/%h func=%b a0=%h a1=%h, expected all 0",
                     rsp_addr, rsp_data, mu_func, mu_addr0, mu_addr1);
        else n_pass++;
    endtask

    task automatic test_ready_hold();
        logic [NUM_REQ-1:0] g;
        bit                 ok;
        int                 lat;
        drive_req(0, 2'b00, 10'h005, 10'h000);
        push_exp(0, 2'b00, 10'h005);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (grant !== '0 || mu_execute !== 1'b0)
                $display("FAIL hold_not_ready: grant=%b exec=%b, expected 000/0", grant, mu_execute);
            else n_pass++;
        end
        mem_hold_low = 1'b0;
        wait_grant(g, ok);
        n_checks++;
        if (!ok || g !== 3'b001 || mu_execute !== 1'b1 || busy !== 1'b1)
            $display("FAIL first_grant: ok=%0d grant=%b exec=%b busy=%b, expected 001/1/1", ok, g, mu_execute, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (mu_execute !== 1'b0)
            $display("FAIL exec_one_cycle: exec=%b, expected 0", mu_execute);
        else n_pass++;
        wait_done(lat, ok);
        req[0] = 1'b0;
        n_checks++;
        if (!ok || lat + 1 != 5)
            $display("FAIL car_latency: ok=%0d latency=%0d, expected 5", ok, lat + 1);
        else n_pass++;
    endtask

    task automatic test_cdr_contents();
        logic [NUM_REQ-1:0] g;
        bit                 ok;
        int                 lat;
        for (int k = 0; k < 2; k++) begin
            drive_req(1, (k == 0) ? 2'b01 : 2'b11, 10'h005, 10'h000);
            push_exp(1, (k == 0) ? 2'b01 : 2'b11, 10'h005);
            wait_grant(g, ok);
            n_checks++;
            if (!ok || g !== 3'b010)
                $display("FAIL req1_grant%0d: ok=%0d grant=%b, expected 010", k, ok, g);
            else n_pass++;
            wait_done(lat, ok);
            req[1] = 1'b0;
            n_checks++;
            if (!ok || lat != 5)
                $display("FAIL req1_done%0d: ok=%0d latency=%0d, expected 5", k, ok, lat);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] g;
        logic [NUM_REQ-1:0] exp_g;
        bit                 ok;
        int                 lat;
        apply_reset();
        drive_req(0, 2'b00, 10'h005, 10'h000);
        drive_req(1, 2'b01, 10'h006, 10'h000);
        drive_req(2, 2'b00, 10'h007, 10'h000);
        push_exp(0, 2'b00, 10'h005);
        push_exp(1, 2'b01, 10'h006);
        push_exp(2, 2'b00, 10'h007);
        push_exp(0, 2'b00, 10'h005);
        for (int k = 0; k < 4; k++) begin
            wait_grant(g, ok);
            if (k == 3) req = '0;
            exp_g = '0;
            exp_g[k % 3] = 1'b1;
            n_checks++;
            if (!ok || g !== exp_g)
                $display("FAIL rr_grant%0d: ok=%0d grant=%b, expected %b", k, ok, g, exp_g);
            else n_pass++;
            wait_done(lat, ok);
            n_checks++;
            if (!ok)
                $display("FAIL rr_done%0d: no done within bound, got timeout expected done", k);
            else n_pass++;
        end
    endtask

    task automatic test_cons_timeout();
        logic [NUM_REQ-1:0] g;
        bit                 ok;
        int                 lat;
        drive_req(2, 2'b10, 10'h001, 10'h002);
        push_exp(2, 2'b10, 10'h001);
        wait_grant(g, ok);
        n_checks++;
        if (!ok || g !== 3'b100 || mu_func !== 2'b10 || mu_addr0 !== 10'h001 || mu_addr1 !== 10'h002)
            $display("FAIL cons_issue: ok=%0d grant=%b func=%b a0=%h a1=%h, expected 100/10/001/002",
                     ok, g, mu_func, mu_addr0, mu_addr1);
        else n_pass++;
        wait_done(lat, ok);
        req[2] = 1'b0;
        n_checks++;
        if (!ok || lat != TIMEOUT + 1)
            $display("FAIL cons_timeout_lat: ok=%0d latency=%0d, expected %0d", ok, lat, TIMEOUT + 1);
        else n_pass++;
        n_checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || grant !== '0)
            $display("FAIL cons_abort_state: to=%b busy=%b grant=%b, expected 1/0/000", timeout_err, busy, grant);
        else n_pass++;
        mem_hold_low = 1'b1;
        tick();
        mem_hold_low = 1'b0;
        tick();
        tick();
        n_checks++;
        if (mu_func !== 2'b10 || mu_addr0 !== 10'h001 || mu_addr1 !== 10'h002 || timeout_err !== 1'b0)
            $display("FAIL cons_hold_cmd: func=%b a0=%h a1=%h to=%b, expected 10/001/002/0",
                     mu_func, mu_addr0, mu_addr1, timeout_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        logic [NUM_REQ-1:0] g;
        bit                 ok;
        bit                 saw_done;
        drive_req(0, 2'b00, 10'h006, 10'h000);
        wait_grant(g, ok);
        n_checks++;
        if (!ok || g !== 3'b001)
            $display("FAIL rst_run_grant: ok=%0d grant=%b, expected 001", ok, g);
        else n_pass++;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({grant, done, timeout_err, busy, mu_execute, mu_func, mu_addr0, mu_addr1, rsp_addr, rsp_data} !== '0)
            $display("FAIL rst_run_outputs: grant=%b done=%b busy=%b func=%b a0=%h rsp=%h/%h, expected all 0",
                     grant, done, busy, mu_func, mu_addr0, rsp_addr, rsp_data);
        else n_pass++;
        req      = '0;
        rst      = 1'b0;
        mdl_addr = '0;
        mdl_data = '0;
        saw_done = 1'b0;
        repeat (8) begin
            tick();
            if (done !== '0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done)
            $display("FAIL rst_run_no_done: done pulse seen=1, expected 0");
        else n_pass++;
    endtask

    task automatic test_operand_hold();
        logic [NUM_REQ-1:0] g;
        bit                 ok;
        int                 lat;
        drive_req(0, 2'b00, 10'h005, 10'h000);
        push_exp(0, 2'b00, 10'h005);
        wait_grant(g, ok);
        n_checks++;
        if (!ok || g !== 3'b001)
            $display("FAIL op_grant: ok=%0d grant=%b, expected 001", ok, g);
        else n_pass++;
        drive_req(0, 2'b01, 10'h3FF, 10'h155);
        req[0] = 1'b0;
        tick();
        n_checks++;
        if (mu_addr0 !== 10'h005 || mu_func !== 2'b00 || mu_addr1 !== 10'h000 || grant !== 3'b001)
            $display("FAIL op_latched: a0=%h func=%b a1=%h grant=%b, expected 005/00/000/001",
                     mu_addr0, mu_func, mu_addr1, grant);
        else n_pass++;
        wait_done(lat, ok);
        n_checks++;
        if (!ok)
            $display("FAIL op_done: no done within bound, expected done");
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_ready_hold();
        test_cdr_contents();
        test_round_robin();
        test_cons_timeout();
        test_reset_mid_run();
        test_operand_hold();
        tick();
        tick();
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL sb_drained: %0d expectations left, expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
